// File: rtl/seq_table_timer.sv
// ============================================================================
// Module   : seq_table_timer
// Purpose  : Table-driven pulse-sequence timer with repeat, loop and abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_table_timer #(
  parameter  int NSEG    = 8,
  parameter  int CNT_W   = 16,
  parameter  int OUT_W   = 8,
  parameter  int REP_W   = 8,
  localparam int c_IDX_W = $clog2(NSEG)
) (
  input  logic               i_clk_sys,
  input  logic               i_rst_n,
  input  logic [c_IDX_W-1:0] i_load_idx,
  input  logic [CNT_W-1:0]   i_load_time,
  input  logic [OUT_W-1:0]   i_load_mask,
  input  logic               i_load_en,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_cont_mode,
  input  logic [REP_W-1:0]   i_rep_cfg,
  output logic [OUT_W-1:0]   o_seq_out,
  output logic [c_IDX_W-1:0] o_seg_idx,
  output logic               o_busy,
  output logic               o_seg_end,
  output logic               o_done,
  output logic               o_aborted,
  output logic               o_load_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_time [NSEG];
  logic [OUT_W-1:0]   r_mask [NSEG];
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [c_IDX_W-1:0] r_seg;
  logic [c_IDX_W-1:0] w_seg_nxt;
  logic [REP_W-1:0]   r_pass;
  logic [REP_W-1:0]   w_pass_nxt;
  logic               r_cont;
  logic               w_cont_nxt;
  logic [OUT_W-1:0]   r_seq_out;
  logic [OUT_W-1:0]   w_seq_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               r_aborted;
  logic               w_abort_nxt;
  logic               r_load_err;
  logic [c_IDX_W-1:0] w_nxt_idx;
  logic               w_last_seg;
  logic               w_seg_end;

  // The table has no reset: contents survive a reset so a run can be replayed.
  always_ff @(posedge i_clk_sys) begin
    if (i_load_en && (r_state == S_IDLE)) begin
      r_time[i_load_idx] <= i_load_time;
      r_mask[i_load_idx] <= i_load_mask;
    end
  end

  // A zero duration beyond segment 0 terminates the pass early.
  always_comb begin
    w_nxt_idx  = '0;
    w_last_seg = 1'b1;
    if (r_seg != c_IDX_W'(NSEG - 1)) begin
      w_nxt_idx  = r_seg + c_IDX_W'(1);
      w_last_seg = (r_time[w_nxt_idx] == '0);
    end
  end

  assign w_seg_end = (r_state == S_RUN) && (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_seg_nxt   = r_seg;
    w_pass_nxt  = r_pass;
    w_cont_nxt  = r_cont;
    w_seq_nxt   = r_seq_out;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop && (r_time[0] != '0)) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = r_time[0] - CNT_W'(1);
          w_seg_nxt   = '0;
          w_seq_nxt   = r_mask[0];
          w_pass_nxt  = i_rep_cfg;
          w_cont_nxt  = i_cont_mode;
        end
      end
      S_RUN: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_seg_nxt   = '0;
          w_seq_nxt   = '0;
          w_abort_nxt = 1'b1;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (!w_last_seg) begin
          w_seg_nxt = w_nxt_idx;
          w_cnt_nxt = r_time[w_nxt_idx] - CNT_W'(1);
          w_seq_nxt = r_mask[w_nxt_idx];
        end else if (r_cont || (r_pass != '0)) begin
          w_seg_nxt = '0;
          w_cnt_nxt = r_time[0] - CNT_W'(1);
          w_seq_nxt = r_mask[0];
          if (!r_cont) begin
            w_pass_nxt = r_pass - REP_W'(1);
          end
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_seg_nxt   = '0;
          w_seq_nxt   = '0;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_seg      <= '0;
      r_pass     <= '0;
      r_cont     <= 1'b0;
      r_seq_out  <= '0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_seg      <= w_seg_nxt;
      r_pass     <= w_pass_nxt;
      r_cont     <= w_cont_nxt;
      r_seq_out  <= w_seq_nxt;
      r_done     <= w_done_nxt;
      r_aborted  <= w_abort_nxt;
      r_load_err <= i_load_en && (r_state == S_RUN);
    end
  end

  assign o_seq_out  = r_seq_out;
  assign o_seg_idx  = r_seg;
  assign o_busy     = (r_state == S_RUN);
  assign o_seg_end  = w_seg_end;
  assign o_done     = r_done;
  assign o_aborted  = r_aborted;
  assign o_load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_seq_table_timer.sv
// ============================================================================
// Module   : tb_seq_table_timer
// Purpose  : Directed and random checks of seq_table_timer against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_table_timer;

  localparam int NSEG  = 8;
  localparam int CNT_W = 16;
  localparam int OUT_W = 8;
  localparam int REP_W = 8;
  localparam int IW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IW-1:0]    load_idx;
  logic [CNT_W-1:0] load_time;
  logic [OUT_W-1:0] load_mask;
  logic             load_en, start, stop, cont_mode;
  logic [REP_W-1:0] rep_cfg;
  wire  [OUT_W-1:0] seq_out;
  wire  [IW-1:0]    seg_idx;
  wire              busy, seg_end, done, aborted, load_err;

  always #5 clk = ~clk;

  seq_table_timer #(.NSEG(NSEG), .CNT_W(CNT_W), .OUT_W(OUT_W), .REP_W(REP_W)) dut (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_load_idx(load_idx), .i_load_time(load_time),
    .i_load_mask(load_mask), .i_load_en(load_en), .i_start(start), .i_stop(stop),
    .i_cont_mode(cont_mode), .i_rep_cfg(rep_cfg), .o_seq_out(seq_out), .o_seg_idx(seg_idx),
    .o_busy(busy), .o_seg_end(seg_end), .o_done(done), .o_aborted(aborted),
    .o_load_err(load_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a run is expanded into one queue entry per output cycle.
  typedef struct {
    logic [OUT_W-1:0] m;
    int               idx;
    bit               last;
  } ent_t;

  ent_t             q[$];
  int               m_time [NSEG];
  logic [OUT_W-1:0] m_mask [NSEG];
  int               m_pass;
  bit               m_cont;
  bit               e_done, e_abort, e_lerr;
  int               n_busy, n_done, n_segend, n_abort, n_lerr, max_idx;

  function automatic void push_pass();
    for (int j = 0; j < NSEG; j++) begin
      if (j > 0 && m_time[j] == 0) break;
      for (int k = 0; k < m_time[j]; k++) begin
        ent_t e;
        e.m    = m_mask[j];
        e.idx  = j;
        e.last = (k == m_time[j] - 1);
        q.push_back(e);
      end
    end
  endfunction

  function automatic void model_step();
    bit run;
    run     = (q.size() != 0);
    e_lerr  = load_en && run;
    e_done  = 1'b0;
    e_abort = 1'b0;
    if (run) begin
      if (stop) begin
        q.delete();
        e_abort = 1'b1;
      end else begin
        q.delete(0);
        if (q.size() == 0) begin
          if (m_cont) push_pass();
          else if (m_pass > 0) begin
            m_pass--;
            push_pass();
          end else e_done = 1'b1;
        end
      end
    end else if (start && !stop && m_time[0] != 0) begin
      m_pass = int'(rep_cfg);
      m_cont = cont_mode;
      push_pass();
    end
    if (load_en && !run) begin
      m_time[load_idx] = int'(load_time);
      m_mask[load_idx] = load_mask;
    end
  endfunction

  task automatic tick();
    logic [OUT_W-1:0] x_seq;
    int               x_idx;
    bit               x_busy, x_se;
    model_step();
    @(posedge clk);
    #1;
    x_seq  = '0;
    x_idx  = 0;
    x_busy = 1'b0;
    x_se   = 1'b0;
    if (q.size() != 0) begin
      x_seq  = q[0].m;
      x_idx  = q[0].idx;
      x_busy = 1'b1;
      x_se   = q[0].last;
    end
    check_val("seq_out", 32'(seq_out), 32'(x_seq));
    check_val("seg_idx", 32'(seg_idx), 32'(x_idx));
    check_val("flags{busy,seg_end,done,aborted,load_err}",
              32'({busy, seg_end, done, aborted, load_err}),
              32'({x_busy, x_se, e_done, e_abort, e_lerr}));
    n_busy   += int'(busy);
    n_done   += int'(done);
    n_segend += int'(seg_end);
    n_abort  += int'(aborted);
    n_lerr   += int'(load_err);
    if (int'(seg_idx) > max_idx) max_idx = int'(seg_idx);
    @(negedge clk);
  endtask

  task automatic clr_cnt();
    n_busy = 0; n_done = 0; n_segend = 0; n_abort = 0; n_lerr = 0; max_idx = 0;
  endtask

  task automatic load(input int idx, input int t, input logic [OUT_W-1:0] m);
    load_idx  = IW'(idx);
    load_time = CNT_W'(t);
    load_mask = m;
    load_en   = 1'b1;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic run_to_idle();
    int i;
    i = 0;
    while (q.size() != 0 && i < 400) begin
      tick();
      i++;
    end
    check_val("run_bound", 32'(i < 400), 32'd1);
  endtask

  task automatic do_start(input int rep, input bit cm);
    rep_cfg   = REP_W'(rep);
    cont_mode = cm;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic load_base();
    load(0, 4, 8'h01);
    load(1, 2, 8'h02);
    load(2, 3, 8'h04);
    load(3, 0, 8'h88);
    for (int j = 4; j < NSEG; j++) load(j, $urandom_range(1, 5), 8'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; load_idx = '0; load_time = '0; load_mask = '0; load_en = 1'b0;
    start = 1'b0; stop = 1'b0; cont_mode = 1'b0; rep_cfg = '0;
    m_pass = 0; m_cont = 1'b0;
    for (int j = 0; j < NSEG; j++) begin m_time[j] = 0; m_mask[j] = '0; end
    clr_cnt();
    #3;
    check_val("reset_outputs",
              32'({seq_out, seg_idx, busy, seg_end, done, aborted, load_err}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    load_base();

    // single pass with terminator
    clr_cnt();
    do_start(0, 1'b0);
    run_to_idle();
    check_val("single_busy_cycles", 32'(n_busy), 32'd9);
    check_val("single_done_count", 32'(n_done), 32'd1);
    check_val("single_seg_end_count", 32'(n_segend), 32'd3);

    // three passes back to back
    clr_cnt();
    do_start(2, 1'b0);
    run_to_idle();
    check_val("repeat_busy_cycles", 32'(n_busy), 32'd27);
    check_val("repeat_done_count", 32'(n_done), 32'd1);

    // continuous mode, stop on cycle 20 of RUN
    clr_cnt();
    do_start(0, 1'b1);
    repeat (19) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();
    check_val("cont_abort_count", 32'(n_abort), 32'd1);
    check_val("cont_done_count", 32'(n_done), 32'd0);
    check_val("cont_busy_cycles", 32'(n_busy), 32'd20);

    // write attempted during a run is rejected
    clr_cnt();
    do_start(0, 1'b0);
    repeat (2) tick();
    load(1, 9, 8'h55);
    run_to_idle();
    check_val("load_err_count", 32'(n_lerr), 32'd1);
    clr_cnt();
    do_start(0, 1'b0);
    run_to_idle();
    check_val("after_reject_busy", 32'(n_busy), 32'd9);

    // time[0]==0 blocks start
    load(0, 0, 8'h11);
    clr_cnt();
    do_start(0, 1'b0);
    repeat (4) tick();
    check_val("zero_t0_busy", 32'(n_busy + n_done + n_abort), 32'd0);
    load(0, 4, 8'h01);

    // start and stop together in IDLE
    clr_cnt();
    stop = 1'b1;
    do_start(0, 1'b0);
    stop = 1'b0;
    repeat (3) tick();
    check_val("start_stop_idle", 32'(n_busy + n_done + n_abort), 32'd0);

    // all segments populated
    for (int j = 0; j < NSEG; j++) load(j, $urandom_range(1, 3), 8'($urandom));
    clr_cnt();
    do_start(0, 1'b0);
    run_to_idle();
    check_val("full_max_idx", 32'(max_idx), 32'd7);
    check_val("full_done_count", 32'(n_done), 32'd1);
    check_val("full_seg_end_count", 32'(n_segend), 32'd8);

    // asynchronous reset during segment 1
    do_start(1, 1'b0);
    for (int i = 0; i < 20 && q.size() != 0 && q[0].idx != 1; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_outputs",
              32'({seq_out, seg_idx, busy, seg_end, done, aborted}), 32'd0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr_cnt();
    do_start(0, 1'b0);
    run_to_idle();
    check_val("post_rst_done", 32'(n_done), 32'd1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      load_en   = !start && ($urandom_range(0, 5) == 0);
      load_idx  = IW'($urandom_range(0, NSEG - 1));
      load_time = CNT_W'($urandom_range(0, 5));
      load_mask = OUT_W'($urandom);
      cont_mode = ($urandom_range(0, 3) == 0);
      rep_cfg   = REP_W'($urandom_range(0, 3));
      tick();
    end
    start = 1'b0; load_en = 1'b0;
    stop  = 1'b1;
    tick();
    stop  = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
